controle_semaforo: RTL
======================

CONTROLE_SEMAFORO -- requirements
Module: controle_semaforo

Interface
REQ-001 SHALL have parameter TICKS_POR_SEG, default 1, meaning clk cycles per countdown step when `tick` is tied high (1 = step on every `tick` pulse).
REQ-002 SHALL have port `clk`, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst_n`, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port `tick`, input, 1 bit, countdown enable; a step occurs on a clk edge where tick=1 and the prescaler reaches TICKS_POR_SEG.
REQ-005 SHALL have port `casoEsp`, input, 1 bit, selects the special preset table.
REQ-006 SHALL have port `pedido`, input, 1 bit, pedestrian request, level-sampled every clk.
REQ-007 SHALL have port `noturno`, input, 1 bit, night-blink request (see Configuration).
REQ-008 SHALL have port `estado`, output, 2 bits: 00 VERDE, 01 AMARELO, 10 VERMELHO, 11 PISCA.
REQ-009 SHALL have port `unid`, output, 4 bits, BCD units of remaining time (0-9).
REQ-010 SHALL have port `dez`, output, 2 bits, BCD tens of remaining time (0-3).
REQ-011 SHALL have ports `luz_vd`, `luz_am`, `luz_vm`, each output, 1 bit, lamp drives, registered.
REQ-012 SHALL have port `fim_fase`, output, 1 bit, one-clk pulse on every phase transition.

Function
REQ-013 SHALL use presets (dez:unid): normal VERDE 25, AMARELO 05, VERMELHO 20; casoEsp=1 VERDE 15, AMARELO 05, VERMELHO 30.
REQ-014 SHALL sequence VERDE->AMARELO->VERMELHO->VERDE.
REQ-015 SHALL decrement the count in BCD on each step; unid 0 wraps to 9 with dez-1.
REQ-016 SHALL, on a step when the count is 01, change phase, load the next phase preset in that same edge, and pulse fim_fase; a phase with preset N therefore lasts exactly N steps, displaying N..1.
REQ-017 SHALL never display 00 or an invalid BCD value outside PISCA.
REQ-018 SHALL sample casoEsp only at preset load; a change mid-phase takes effect at the next load.
REQ-019 SHALL set an internal pedido_pend flag when pedido=1, in any state.
REQ-020 SHALL, on a step in VERDE with pedido_pend=1 and count > 15, load 15 instead of decrementing; if count <= 15, it decrements normally.
REQ-021 SHALL clear pedido_pend on entry to VERMELHO; pedido=1 on that same edge keeps it set.
REQ-022 SHALL drive lamps one-hot per state: VERDE luz_vd, AMARELO luz_am, VERMELHO luz_vm.
REQ-023 SHALL update lamps on the same edge as estado, with no extra latency.
REQ-024 SHALL not step when tick=0; state and count hold.

Reset
REQ-025 SHALL, while rst_n=0, force estado=10, dez:unid=20, luz_vm=1, luz_vd=0, luz_am=0, fim_fase=0, pedido_pend=0, prescaler=0, regardless of casoEsp.
REQ-026 SHALL, on rst_n assertion mid-phase, immediately abandon the phase; the first step after release decrements from 20.

Configuration
REQ-027 SHALL, with macro PISCA_NOTURNO_EN defined, enter PISCA from any state when noturno=1; entry is at the next step and pulses fim_fase.
REQ-028 SHALL, in PISCA, hold the count at 00, keep luz_vd=luz_vm=0, and toggle luz_am on every step.
REQ-029 SHALL, in PISCA when noturno returns to 0, go to VERMELHO at the next step, loading its preset.
REQ-030 SHALL, without PISCA_NOTURNO_EN, keep the noturno port but ignore it; encoding 11 is then never reached.

Verification
REQ-031 SHALL cover: reset release, casoEsp=0, tick=1 -> VERMELHO 20..01 over 20 clks, then VERDE 25, fim_fase pulses once.
REQ-032 SHALL cover: full normal cycle -> VERDE 25 steps, AMARELO 5, VERMELHO 20; total 50 steps back to VERDE.
REQ-033 SHALL cover: pedido pulse of 1 clk at VERDE count 22 -> next step shows 15, then 14..01, AMARELO 05; pedido_pend cleared at VERMELHO.
REQ-034 SHALL cover: casoEsp toggled 0->1 at VERMELHO count 10 -> count continues 09..01; next VERDE loads 15, next VERMELHO loads 30.
REQ-035 SHALL cover: BCD wrap -> after 20, step shows 19; after 10, step shows 09; no A-F values in unid.
REQ-036 SHALL cover, with PISCA_NOTURNO_EN: noturno=1 in VERDE at 12 -> next step estado=11, luz_am toggles per step; noturno=0 -> VERMELHO 20; tick=0 freezes everything; rst_n low mid-PISCA -> VERMELHO 20 immediately.

Source files
------------

// File: rtl/controle_semaforo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : controle_semaforo
// Brief    : Traffic-light controller with BCD countdown, pedestrian shortcut
//            and optional night blink mode (macro PISCA_NOTURNO_EN).
// Revision : 1.0
// ============================================================================
module controle_semaforo #(
    parameter int TICKS_POR_SEG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       casoEsp,
    input  logic       pedido,
    input  logic       noturno,
    output logic [1:0] estado,
    output logic [3:0] unid,
    output logic [1:0] dez,
    output logic       luz_vd,
    output logic       luz_am,
    output logic       luz_vm,
    output logic       fim_fase
);

    localparam logic [1:0] S_VERDE    = 2'b00;
    localparam logic [1:0] S_AMARELO  = 2'b01;
    localparam logic [1:0] S_VERMELHO = 2'b10;
    localparam logic [1:0] S_PISCA    = 2'b11;

    localparam int             PW          = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
    localparam logic [PW-1:0]  C_PRESC_MAX = PW'(TICKS_POR_SEG - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_estado;
    logic [1:0]    r_dez;
    logic [3:0]    r_unid;
    logic          r_pend;
    logic          r_luz_vd, r_luz_am, r_luz_vm;
    logic          r_fim;

    logic          w_step;
    logic          w_pend_eff;
    logic [1:0]    w_estado_nx;
    logic [1:0]    w_dez_nx;
    logic [3:0]    w_unid_nx;
    logic          w_fim_nx;
    logic          w_am_nx;
    logic          w_entra_vm;

    // Preset packed as {dez, unid}; casoEsp only matters at load time.
    function automatic logic [5:0] preset(input logic [1:0] s, input logic caso);
        case (s)
            S_VERDE:   preset = caso ? {2'd1, 4'd5} : {2'd2, 4'd5};
            S_AMARELO: preset = {2'd0, 4'd5};
            default:   preset = caso ? {2'd3, 4'd0} : {2'd2, 4'd0};
        endcase
    endfunction

    function automatic logic [1:0] proxima(input logic [1:0] s);
        case (s)
            S_VERDE:   proxima = S_AMARELO;
            S_AMARELO: proxima = S_VERMELHO;
            default:   proxima = S_VERDE;
        endcase
    endfunction

    assign w_step     = tick && (r_presc == C_PRESC_MAX);
    assign w_pend_eff = r_pend | pedido;

`ifndef PISCA_NOTURNO_EN
    wire w_unused_noturno = noturno;
`endif

    always_comb begin
        w_estado_nx = r_estado;
        w_dez_nx    = r_dez;
        w_unid_nx   = r_unid;
        w_fim_nx    = 1'b0;
        w_am_nx     = r_luz_am;
        if (w_step) begin
`ifdef PISCA_NOTURNO_EN
            if (noturno) begin
                if (r_estado == S_PISCA) begin
                    w_am_nx = ~r_luz_am;
                end else begin
                    w_estado_nx = S_PISCA;
                    w_fim_nx    = 1'b1;
                    w_am_nx     = 1'b1;
                end
                w_dez_nx  = 2'd0;
                w_unid_nx = 4'd0;
            end else if (r_estado == S_PISCA) begin
                w_estado_nx             = S_VERMELHO;
                {w_dez_nx, w_unid_nx}   = preset(S_VERMELHO, casoEsp);
                w_fim_nx                = 1'b1;
            end else
`endif
            if (r_dez == 2'd0 && r_unid == 4'd1) begin
                w_estado_nx           = proxima(r_estado);
                {w_dez_nx, w_unid_nx} = preset(proxima(r_estado), casoEsp);
                w_fim_nx              = 1'b1;
            end else if (r_estado == S_VERDE && w_pend_eff &&
                         (r_dez > 2'd1 || (r_dez == 2'd1 && r_unid > 4'd5))) begin
                w_dez_nx  = 2'd1;
                w_unid_nx = 4'd5;
            end else if (r_unid == 4'd0) begin
                w_unid_nx = 4'd9;
                w_dez_nx  = r_dez - 2'd1;
            end else begin
                w_unid_nx = r_unid - 4'd1;
            end
        end
        // Outside PISCA the amber lamp simply follows the state.
        if (w_estado_nx != S_PISCA)
            w_am_nx = (w_estado_nx == S_AMARELO);
    end

    assign w_entra_vm = (w_estado_nx == S_VERMELHO) && (r_estado != S_VERMELHO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_estado <= S_VERMELHO;
            r_dez    <= 2'd2;
            r_unid   <= 4'd0;
            r_pend   <= 1'b0;
            r_luz_vd <= 1'b0;
            r_luz_am <= 1'b0;
            r_luz_vm <= 1'b1;
            r_fim    <= 1'b0;
        end else begin
            if (tick)
                r_presc <= w_step ? '0 : r_presc + 1'b1;
            r_estado <= w_estado_nx;
            r_dez    <= w_dez_nx;
            r_unid   <= w_unid_nx;
            r_pend   <= pedido | (r_pend & ~w_entra_vm);
            r_luz_vd <= (w_estado_nx == S_VERDE);
            r_luz_am <= w_am_nx;
            r_luz_vm <= (w_estado_nx == S_VERMELHO);
            r_fim    <= w_fim_nx;
        end
    end

    assign estado   = r_estado;
    assign dez      = r_dez;
    assign unid     = r_unid;
    assign luz_vd   = r_luz_vd;
    assign luz_am   = r_luz_am;
    assign luz_vm   = r_luz_vm;
    assign fim_fase = r_fim;

endmodule
`default_nettype wire
